t_frag_cfg_ctrl: RTL

Configuration sequencer for a column of N_FRAGS T_FRAG logic cells. It holds a shadow copy of each cell's four input-inverter selects (XAS1, XAS2, XBS1, XBS2), written by a host over a valid/ready port. On commit it quiesces the column by driving TBS low, which forces every XZ to 0. It then shifts the shadow bits into the fabric configuration chain, pulses a latch, and re-enables TBS. It sits between the configuration host/testbench and the C_FRAG column configuration chain.

---
 rtl/t_frag_cfg_pkg.sv | 20 ++
 rtl/t_frag_cfg_shifter.sv | 39 +++
 rtl/t_frag_cfg_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/t_frag_cfg_pkg.sv
// Shared types and constants for the T_FRAG column configuration sequencer.
package t_frag_cfg_pkg;

  localparam int CFG_BITS_PER_FRAG = 4;

  // Bit positions of the inverter selects inside one cell's 4-bit field.
  localparam int INV_XAS1 = 3;
  localparam int INV_XAS2 = 2;
  localparam int INV_XBS1 = 1;
  localparam int INV_XBS2 = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUIESCE,
    S_SHIFT,
    S_LATCH,
    S_SETTLE
  } cfg_state_e;

endpackage

// File: rtl/t_frag_cfg_shifter.sv
// Parallel-load, MSB-first shift register with a saturating shift counter.
module t_frag_cfg_shifter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             shift,
  output logic             msb,
  output logic             last,
  output logic             tc
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= data;
      cnt  <= '0;
    end else if (shift && !tc) begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
      cnt  <= cnt + 1'b1;
    end
  end

  assign msb  = sreg[WIDTH-1];
  assign last = (cnt == CNT_W'(WIDTH - 1));
  assign tc   = (cnt == CNT_W'(WIDTH));

endmodule

// File: rtl/t_frag_cfg_ctrl.sv
// Configuration sequencer: shadows per-cell inverter selects, then quiesces the
// column (TBS=0), shifts the shadow into the chain, latches and re-enables TBS.
module t_frag_cfg_ctrl
  import t_frag_cfg_pkg::*;
#(
  parameter int N_FRAGS     = 8,
  parameter int IDX_W       = 3,
  parameter int QUIESCE_CYC = 2,
  parameter int SETTLE_CYC  = 2
) (
  input  logic                         QCK,
  input  logic                         QRT,
  input  logic                         CFG_VALID,
  output logic                         CFG_READY,
  input  logic [IDX_W-1:0]             CFG_IDX,
  input  logic [CFG_BITS_PER_FRAG-1:0] CFG_INV,
  input  logic                         CFG_COMMIT,
  output logic                         CFG_BUSY,
  output logic                         CFG_DONE,
  output logic                         CFG_ERR,
  output logic                         SHIFT_EN,
  output logic                         SHIFT_DO,
  output logic                         LATCH,
  output logic                         TBS
);

  localparam int CHAIN_W = CFG_BITS_PER_FRAG * N_FRAGS;
  localparam int PH_W    = 8;

  logic [N_FRAGS-1:0][CFG_BITS_PER_FRAG-1:0] shadow;
  cfg_state_e      state;
  logic [PH_W-1:0] phase;
  logic            accept;
  logic            idx_ok;
  logic            load;
  logic            shift;
  logic            sh_msb;
  logic            sh_last;
  logic            sh_tc;

  assign accept = CFG_VALID & CFG_READY;
  assign idx_ok = (int'(CFG_IDX) < N_FRAGS);
  assign load   = (state == S_QUIESCE) && (phase == PH_W'(QUIESCE_CYC - 1));
  assign shift  = (state == S_SHIFT);

  // NOTE: the shadow is a register array, not a RAM, so it takes the async
  // reset; a cleared shadow is what the first commit after reset loads.
  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      shadow  <= '0;
      CFG_ERR <= 1'b0;
    end else if (accept) begin
      if (idx_ok) shadow[CFG_IDX] <= CFG_INV;
      else        CFG_ERR         <= 1'b1;
    end
  end

  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      state     <= S_IDLE;
      phase     <= '0;
      CFG_READY <= 1'b1;
      CFG_BUSY  <= 1'b0;
      CFG_DONE  <= 1'b0;
      SHIFT_EN  <= 1'b0;
      LATCH     <= 1'b0;
      TBS       <= 1'b0;
    end else begin
      CFG_DONE <= 1'b0;
      LATCH    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (CFG_COMMIT) begin
            state     <= S_QUIESCE;
            phase     <= '0;
            CFG_READY <= 1'b0;
            CFG_BUSY  <= 1'b1;
            TBS       <= 1'b0;
          end
        end
        S_QUIESCE: begin
          if (load) begin
            state    <= S_SHIFT;
            SHIFT_EN <= 1'b1;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        S_SHIFT: begin
          if (sh_last) begin
            state    <= S_LATCH;
            SHIFT_EN <= 1'b0;
            LATCH    <= 1'b1;
          end
        end
        S_LATCH: begin
          // The final shift has saturated the counter by the time we get here.
          if (sh_tc) begin
            state <= S_SETTLE;
            phase <= '0;
          end
        end
        S_SETTLE: begin
          if (phase == PH_W'(SETTLE_CYC - 1)) begin
            state     <= S_IDLE;
            TBS       <= 1'b1;
            CFG_DONE  <= 1'b1;
            CFG_READY <= 1'b1;
            CFG_BUSY  <= 1'b0;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  t_frag_cfg_shifter #(
    .WIDTH(CHAIN_W)
  ) u_shifter (
    .clk  (QCK),
    .rst  (QRT),
    .load (load),
    .data (shadow),
    .shift(shift),
    .msb  (sh_msb),
    .last (sh_last),
    .tc   (sh_tc)
  );

  assign SHIFT_DO = SHIFT_EN & sh_msb;

endmodule
